// File: rtl/bch_tx_pkg.sv
// Shared widths, FSM state type and counter-width helper for the BCH transmit
// scheduler and its (21,16) encoder.
package bch_tx_pkg;

  localparam int DATA_W = 16;
  localparam int CW_W   = 21;
  localparam int PAR_W  = 5;

  typedef enum logic [2:0] {IDLE, LOAD, PREAMBLE, PAYLOAD, GAP} tx_state_t;

  // Width of a counter spanning 0..clks_per_bit-1, never narrower than one bit.
  function automatic int period_cnt_w(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/bch_encoder.sv
// Combinational (21,16) single-error-correcting BCH encoder in positional form:
// parity at codeword positions 1,2,4,8,16 (bit index = position-1), data elsewhere.
module bch_encoder
  import bch_tx_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CW_W-1:0]   codeword
);

  logic [CW_W-1:0] cw;
  logic            par;
  int              k;

  always_comb begin
    cw  = '0;
    par = 1'b0;
    k   = 0;
    for (int p = 1; p <= CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = data[k];
        k++;
      end
    end
    // Parity j covers every position whose index has bit j set.
    for (int j = 0; j < PAR_W; j++) begin
      par = 1'b0;
      for (int p = 1; p <= CW_W; p++) begin
        if (((p >> j) & 1) != 0) par = par ^ cw[p-1];
      end
      cw[(1 << j) - 1] = par;
    end
    codeword = cw;
  end

endmodule

// File: rtl/bch_tx_scheduler.sv
// Round-robin two-source transmit scheduler: BCH-encodes each accepted word and
// serializes preamble + codeword MSB-first. Optional macro: BCH_TX_ERR_INJECT_EN.
module bch_tx_scheduler
  import bch_tx_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 4,
  parameter int          PRE_LEN      = 8,
  parameter logic [15:0] PRE_PATTERN  = 16'h00AB,
  parameter int          IDLE_GAP     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
`ifdef BCH_TX_ERR_INJECT_EN
  input  logic              err_inj,
  input  logic [4:0]        err_pos,
`endif
  output logic              tx_bit,
  output logic              tx_en,
  output logic              tx_frame_start,
  output logic              tx_src_id,
  output logic              busy
);

  localparam int               CNT_W    = period_cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]       PRE_LAST = 5'(PRE_LEN - 1);
  localparam logic [3:0]       PRE_TOP  = 4'(PRE_LEN - 1);
  localparam logic [4:0]       CW_LAST  = 5'(CW_W - 1);
  localparam logic [4:0]       GAP_LAST = 5'(IDLE_GAP - 1);

  tx_state_t         state, state_d, field_next;
  logic              last_grant;
  logic [DATA_W-1:0] data_q;
  logic [CW_W-1:0]   cw_q, enc_cw, cw_load;
  logic [4:0]        bit_cnt, bit_cnt_d, field_last;
  logic [CNT_W-1:0]  clk_cnt, clk_cnt_d;
  logic              grant0, grant1, accept;
  logic              tx_bit_d, tx_en_d, frame_start_d;

  bch_encoder u_enc (
    .data     (data_q),
    .codeword (enc_cw)
  );

`ifdef BCH_TX_ERR_INJECT_EN
  logic       err_q;
  logic [4:0] err_pos_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_pos_q <= '0;
    end else if (accept) begin
      err_q     <= err_inj;
      err_pos_q <= err_pos;
    end
  end

  // Positions beyond the codeword leave it untouched.
  assign cw_load = (err_q && (err_pos_q <= CW_LAST)) ? (enc_cw ^ (CW_W'(1) << err_pos_q)) : enc_cw;
`else
  assign cw_load = enc_cw;
`endif

  // A lone requester always wins; on contention the one not served last wins.
  assign grant0     = req0_valid && (!req1_valid || last_grant);
  assign grant1     = req1_valid && (!req0_valid || !last_grant);
  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign busy       = (state != IDLE);

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    clk_cnt_d  = clk_cnt;
    field_last = PRE_LAST;
    field_next = PAYLOAD;
    case (state)
      PAYLOAD: begin
        field_last = CW_LAST;
        field_next = (IDLE_GAP == 0) ? IDLE : GAP;
      end
      GAP: begin
        field_last = GAP_LAST;
        field_next = IDLE;
      end
      default: ;
    endcase

    case (state)
      IDLE: if (accept) state_d = LOAD;
      LOAD: begin
        state_d   = PREAMBLE;
        bit_cnt_d = '0;
        clk_cnt_d = '0;
      end
      default: begin
        if (clk_cnt == CLK_LAST) begin
          clk_cnt_d = '0;
          if (bit_cnt == field_last) begin
            bit_cnt_d = '0;
            state_d   = field_next;
          end else begin
            bit_cnt_d = bit_cnt + 5'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt + 1'b1;
        end
      end
    endcase

    // Outputs are computed from the next state so the registered line matches it.
    tx_en_d       = (state_d == PREAMBLE) || (state_d == PAYLOAD);
    frame_start_d = (state == LOAD);
    tx_bit_d      = 1'b0;
    if (state_d == PREAMBLE)     tx_bit_d = PRE_PATTERN[PRE_TOP - bit_cnt_d[3:0]];
    else if (state_d == PAYLOAD) tx_bit_d = cw_q[CW_LAST - bit_cnt_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      tx_src_id      <= 1'b0;
      data_q         <= '0;
      cw_q           <= '0;
      bit_cnt        <= '0;
      clk_cnt        <= '0;
      tx_bit         <= 1'b0;
      tx_en          <= 1'b0;
      tx_frame_start <= 1'b0;
    end else begin
      state          <= state_d;
      bit_cnt        <= bit_cnt_d;
      clk_cnt        <= clk_cnt_d;
      tx_bit         <= tx_bit_d;
      tx_en          <= tx_en_d;
      tx_frame_start <= frame_start_d;
      if (accept) begin
        data_q     <= grant1 ? req1_data : req0_data;
        last_grant <= grant1;
        tx_src_id  <= grant1;
      end
      if (state == LOAD) cw_q <= cw_load;
    end
  end

endmodule
